// File: rtl/skin_segm_pkg.sv
// skin_segm_pkg: shared thresholds, mask codes and default widths for the skin pipeline
package skin_segm_pkg;
    localparam logic [7:0] DEF_CB_MIN = 8'd77;
    localparam logic [7:0] DEF_CB_MAX = 8'd127;
    localparam logic [7:0] DEF_CR_MIN = 8'd133;
    localparam logic [7:0] DEF_CR_MAX = 8'd173;
    localparam logic [7:0] MASK_ON    = 8'hFF;
    localparam logic [7:0] MASK_OFF   = 8'h00;
    localparam int DEF_X_W   = 11;
    localparam int DEF_Y_W   = 11;
    localparam int DEF_CNT_W = 21;

    function automatic logic in_range(logic [7:0] v, logic [7:0] lo, logic [7:0] hi);
        return v >= lo && v <= hi;
    endfunction
endpackage

// File: rtl/skin_thresh.sv
// skin_thresh: combinational Cb/Cr box test, qualified by data enable
module skin_thresh
    import skin_segm_pkg::*;
#(
    parameter logic [7:0] CB_MIN = DEF_CB_MIN,
    parameter logic [7:0] CB_MAX = DEF_CB_MAX,
    parameter logic [7:0] CR_MIN = DEF_CR_MIN,
    parameter logic [7:0] CR_MAX = DEF_CR_MAX
) (
    input  logic [7:0] cb,
    input  logic [7:0] cr,
    input  logic       de,
    output logic       skin
);
    assign skin = de & in_range(cb, CB_MIN, CB_MAX) & in_range(cr, CR_MIN, CR_MAX);
endmodule

// File: rtl/skin_segm_bbox.sv
// skin_segm_bbox: skin mask stream with 2-cycle aligned sync and per-frame bounding box/count
module skin_segm_bbox
    import skin_segm_pkg::*;
#(
    parameter logic [7:0] CB_MIN = DEF_CB_MIN,
    parameter logic [7:0] CB_MAX = DEF_CB_MAX,
    parameter logic [7:0] CR_MIN = DEF_CR_MIN,
    parameter logic [7:0] CR_MAX = DEF_CR_MAX,
    parameter int X_W   = DEF_X_W,
    parameter int Y_W   = DEF_Y_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [7:0]       Y,
    input  logic [7:0]       Cb,
    input  logic [7:0]       Cr,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic             in_de,
    output logic [7:0]       mask,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic             out_de,
    output logic [X_W-1:0]   bbox_x_min,
    output logic [X_W-1:0]   bbox_x_max,
    output logic [Y_W-1:0]   bbox_y_min,
    output logic [Y_W-1:0]   bbox_y_max,
    output logic [CNT_W-1:0] skin_count,
    output logic             bbox_valid,
    output logic             frame_done
);
    logic [X_W-1:0]   x, x_s1, x_min, x_max, nx_min, nx_max;
    logic [Y_W-1:0]   y, y_s1, y_min, y_max, ny_min, ny_max;
    logic [CNT_W-1:0] cnt, ncnt;
    logic de_d, vs_d, de_fall, vs_rise, skin, skin_s1, de_s1, hs_s1, vs_s1, hit, fe, any, fd;
    logic [7:0] unused_y;

    assign unused_y  = Y;
    assign de_fall   = de_d & ~in_de;
    assign vs_rise   = in_vsync & ~vs_d;
    assign hit       = de_s1 & skin_s1;
    assign fe        = vs_s1 & ~out_vsync;
    assign any       = |ncnt;
    assign frame_done = fd & ce;

    skin_thresh #(
        .CB_MIN(CB_MIN), .CB_MAX(CB_MAX), .CR_MIN(CR_MIN), .CR_MAX(CR_MAX)
    ) u_thresh (
        .cb(Cb), .cr(Cr), .de(in_de), .skin(skin)
    );

    // input-side position: columns count de cycles, rows count de falling edges, vsync rise restarts rows
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {x, y, de_d, vs_d} <= '0;
        end else if (ce) begin
            de_d <= in_de;
            vs_d <= in_vsync;
            x <= de_fall ? '0 : (in_de && x != '1) ? x + 1'b1 : x;
            y <= vs_rise ? '0 : (de_fall && y != '1) ? y + 1'b1 : y;
        end

    // two-stage pipeline: classification + position, then mask and delayed sync
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {skin_s1, de_s1, hs_s1, vs_s1, x_s1, y_s1} <= '0;
            {mask, out_de, out_hsync, out_vsync} <= '0;
        end else if (ce) begin
            skin_s1   <= skin;
            de_s1     <= in_de;
            hs_s1     <= in_hsync;
            vs_s1     <= in_vsync;
            x_s1      <= x;
            y_s1      <= y;
            mask      <= skin_s1 ? MASK_ON : MASK_OFF;
            out_de    <= de_s1;
            out_hsync <= hs_s1;
            out_vsync <= vs_s1;
        end

    // accumulator values with the current stage-1 pixel folded in
    always_comb begin
        ncnt   = (hit && cnt != '1) ? cnt + 1'b1 : cnt;
        nx_min = (hit && x_s1 < x_min) ? x_s1 : x_min;
        nx_max = (hit && x_s1 > x_max) ? x_s1 : x_max;
        ny_min = (hit && y_s1 < y_min) ? y_s1 : y_min;
        ny_max = (hit && y_s1 > y_max) ? y_s1 : y_max;
    end

    // running accumulators, restarted clean at every frame end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {x_min, y_min} <= '1;
            {x_max, y_max, cnt} <= '0;
        end else if (ce) begin
            x_min <= fe ? '1 : nx_min;
            x_max <= fe ? '0 : nx_max;
            y_min <= fe ? '1 : ny_min;
            y_max <= fe ? '0 : ny_max;
            cnt   <= fe ? '0 : ncnt;
        end

    // frame-end latch of box/count; empty frames report an all-zero box
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, skin_count, bbox_valid, fd} <= '0;
        end else if (ce) begin
            fd <= fe;
            if (fe) begin
                bbox_valid <= any;
                skin_count <= ncnt;
                bbox_x_min <= any ? nx_min : '0;
                bbox_x_max <= any ? nx_max : '0;
                bbox_y_min <= any ? ny_min : '0;
                bbox_y_max <= any ? ny_max : '0;
            end
        end
endmodule

// File: tb/tb_skin_segm_bbox.sv
// tb_skin_segm_bbox: randomized frames checked against a per-pixel rule and frame-level box model
module tb_skin_segm_bbox;
    logic        clk = 1'b0, rst_n = 1'b0, ce = 1'b1;
    logic [7:0]  Y = '0, Cb = '0, Cr = '0;
    logic        in_hsync = 1'b0, in_vsync = 1'b0, in_de = 1'b0;
    logic [7:0]  mask;
    logic        out_hsync, out_vsync, out_de, bbox_valid, frame_done;
    logic [10:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
    logic [20:0] skin_count;

    int checks = 0, errors = 0;
    logic [10:0] hist[$];
    int fd_cnt = 0;
    logic [43:0] s_box;
    logic [20:0] s_cnt;
    logic        s_valid;
    bit skin_map[64][48];
    int e_cnt, e_xmin, e_xmax, e_ymin, e_ymax;
    bit toggle = 0;

    skin_segm_bbox dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .Y(Y), .Cb(Cb), .Cr(Cr),
        .in_hsync(in_hsync), .in_vsync(in_vsync), .in_de(in_de),
        .mask(mask), .out_hsync(out_hsync), .out_vsync(out_vsync), .out_de(out_de),
        .bbox_x_min(bbox_x_min), .bbox_x_max(bbox_x_max),
        .bbox_y_min(bbox_y_min), .bbox_y_max(bbox_y_max),
        .skin_count(skin_count), .bbox_valid(bbox_valid), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic bit is_skin(int cb, int cr);
        return cb >= 77 && cb <= 127 && cr >= 133 && cr <= 173;
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        e_cnt = 0; e_xmin = 1 << 30; e_xmax = -1; e_ymin = 1 << 30; e_ymax = -1;
        fd_cnt = 0;
        for (int c = 0; c < 64; c++)
            for (int r = 0; r < 48; r++) skin_map[c][r] = 0;
    endtask

    task automatic set_rect(int x0, int x1, int y0, int y1);
        for (int c = x0; c <= x1; c++)
            for (int r = y0; r <= y1; r++) skin_map[c][r] = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (ce && rst_n) begin
            hist.push_back({(in_de && is_skin(int'(Cb), int'(Cr))) ? 8'hFF : 8'h00, in_de, in_hsync, in_vsync});
            void'(hist.pop_front());
        end
        chk("pipe", 64'({mask, out_de, out_hsync, out_vsync}), 64'(hist[0]));
        if (frame_done === 1'b1) begin
            fd_cnt++;
            s_box = {bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max};
            s_cnt = skin_count;
            s_valid = bbox_valid;
        end
    endtask

    task automatic px(bit de, bit hs, bit vs, int cb, int cr);
        in_de = de; in_hsync = hs; in_vsync = vs;
        Cb = 8'(cb); Cr = 8'(cr); Y = 8'($urandom);
        ce = 1'b1;
        tick();
        if (toggle) begin
            Cb = 8'($urandom); Cr = 8'($urandom); ce = 1'b0;
            tick();
        end
    endtask

    task automatic gen(bit s, output int cb, output int cr);
        cb = int'($urandom_range(255)); cr = int'($urandom_range(255));
        if (s) begin
            cb = int'($urandom_range(127, 77)); cr = int'($urandom_range(173, 133));
        end else case ($urandom_range(3))
            0: cb = int'($urandom_range(76, 0));
            1: cb = int'($urandom_range(255, 128));
            2: cr = int'($urandom_range(132, 0));
            default: cr = int'($urandom_range(255, 174));
        endcase
    endtask

    task automatic body(int w, int h);
        int cb, cr;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                gen(skin_map[c][r], cb, cr);
                if (is_skin(cb, cr)) begin
                    e_cnt++;
                    if (c < e_xmin) e_xmin = c;
                    if (c > e_xmax) e_xmax = c;
                    if (r < e_ymin) e_ymin = r;
                    if (r > e_ymax) e_ymax = r;
                end
                px(1'b1, 1'b0, 1'b0, cb, cr);
            end
            for (int i = 0; i < 6; i++) px(1'b0, i == 1 || i == 2, 1'b0, 100, 150);
        end
    endtask

    task automatic vsync(bit check);
        logic [43:0] eb;
        for (int i = 0; i < 8; i++) px(1'b0, 1'b0, 1'b1, int'($urandom_range(255)), int'($urandom_range(255)));
        for (int i = 0; i < 4; i++) px(1'b0, 1'b0, 1'b0, 100, 150);
        if (check) begin
            eb = e_cnt != 0 ? {11'(e_xmin), 11'(e_xmax), 11'(e_ymin), 11'(e_ymax)} : 44'd0;
            chk("frame_done_pulses", 64'(fd_cnt), 64'd1);
            chk("valid_at_pulse", 64'(s_valid), 64'(e_cnt != 0));
            chk("count_at_pulse", 64'(s_cnt), 64'(e_cnt));
            chk("box_at_pulse", 64'(s_box), 64'(eb));
            chk("box_held", 64'({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max}), 64'(eb));
            chk("count_held", 64'(skin_count), 64'(e_cnt));
        end
        clear_model();
    endtask

    task automatic rst_chk(string tag);
        chk({tag, "_mask"}, 64'(mask), 64'd0);
        chk({tag, "_sync"}, 64'({out_de, out_hsync, out_vsync}), 64'd0);
        chk({tag, "_box"}, 64'({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max}), 64'd0);
        chk({tag, "_count"}, 64'(skin_count), 64'd0);
        chk({tag, "_valid"}, 64'(bbox_valid), 64'd0);
        chk({tag, "_fd"}, 64'(frame_done), 64'd0);
    endtask

    initial begin
        hist = '{11'd0, 11'd0};
        clear_model();
        #12;
        rst_chk("reset");
        @(negedge clk);
        rst_n = 1'b1;
        px(1'b1, 1'b0, 1'b0, 77, 133);
        px(1'b1, 1'b0, 1'b0, 127, 173);
        chk("bnd_77_133", 64'(mask), 64'hFF);
        px(1'b1, 1'b0, 1'b0, 76, 150);
        chk("bnd_127_173", 64'(mask), 64'hFF);
        px(1'b1, 1'b0, 1'b0, 100, 174);
        chk("bnd_76_150", 64'(mask), 64'h00);
        px(1'b0, 1'b1, 1'b0, 100, 150);
        chk("bnd_100_174", 64'(mask), 64'h00);
        px(1'b0, 1'b0, 1'b0, 100, 150);
        chk("blank_100_150", 64'(mask), 64'h00);
        vsync(1'b0);
        set_rect(10, 19, 5, 8);
        body(64, 48);
        vsync(1'b1);
        chk("rect_count", 64'(skin_count), 64'd40);
        chk("rect_box", 64'({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max}), 64'({11'd10, 11'd19, 11'd5, 11'd8}));
        body(64, 48);
        vsync(1'b1);
        chk("empty_valid", 64'(bbox_valid), 64'd0);
        skin_map[0][0] = 1;
        body(64, 48);
        vsync(1'b1);
        chk("origin_count", 64'(skin_count), 64'd1);
        toggle = 1;
        set_rect(10, 19, 5, 8);
        body(64, 48);
        vsync(1'b1);
        toggle = 0;
        chk("ce_rect_count", 64'(skin_count), 64'd40);
        for (int c = 0; c < 32; c++)
            for (int r = 0; r < 16; r++) skin_map[c][r] = $urandom_range(7) == 0;
        body(32, 16);
        vsync(1'b1);
        set_rect(10, 19, 0, 2);
        body(64, 2);
        #3;
        rst_n = 1'b0;
        #1;
        rst_chk("midrst");
        hist = '{11'd0, 11'd0};
        for (int i = 0; i < 3; i++) px(1'b0, 1'b0, 1'b0, 100, 150);
        rst_n = 1'b1;
        px(1'b0, 1'b0, 1'b0, 100, 150);
        chk("post_rst_fd", 64'(fd_cnt), 64'd0);
        vsync(1'b0);
        set_rect(30, 32, 20, 22);
        body(64, 24);
        vsync(1'b1);
        chk("blk_count", 64'(skin_count), 64'd9);
        chk("blk_box", 64'({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max}), 64'({11'd30, 11'd32, 11'd20, 11'd22}));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
